// File: rtl/ha_pkg.sv
// Shared defaults and types for the bit-sliced half adder.
package ha_pkg;

  localparam int HA_WIDTH = 1;
  localparam int HA_CNT_W = 16;

  typedef logic [HA_WIDTH-1:0] ha_bits_t;

endpackage

// File: rtl/ha_cell.sv
// Single-bit half adder leaf: sum = a xor b, carry = a and b.
module ha_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// Bit-sliced half adder with a registered copy of the result.
// Optional saturating carry-event counter when HA_STATS_EN is defined.
module half_adder
  import ha_pkg::*;
#(
  parameter int WIDTH = HA_WIDTH
`ifdef HA_STATS_EN
  ,
  parameter int CNT_W = HA_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             valid_q
`ifdef HA_STATS_EN
  ,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ha_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .sum   (sum[i]),
      .carry (carry[i])
    );
  end

  // Valid-only stream, no ready: a/b are captured on every rising edge where
  // in_valid=1; valid_q marks the cycle the captured result is presented.
  // Without in_valid the data registers hold and only valid_q drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= '0;
      valid_q <= 1'b0;
    end else if (in_valid) begin
      sum_q   <= sum;
      carry_q <= carry;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

`ifdef HA_STATS_EN
  // Counts valid cycles with at least one carry-out; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_cnt <= '0;
    end else if (in_valid && (|carry) && (carry_cnt != {CNT_W{1'b1}})) begin
      carry_cnt <= carry_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder (WIDTH=8, CNT_W=2 when HA_STATS_EN).
module tb_half_adder;

  localparam int W      = 8;
  localparam int TB_CNT = 2;
  localparam int SB_W   = 2 * W + 1;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         in_valid;
  logic [W-1:0] sum;
  logic [W-1:0] carry;
  logic [W-1:0] sum_q;
  logic [W-1:0] carry_q;
  logic         valid_q;
`ifdef HA_STATS_EN
  logic [TB_CNT-1:0] carry_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // reference state
  logic [W-1:0] m_sum;
  logic [W-1:0] m_carry;
  logic         m_valid;
  int           m_cnt;
  logic [SB_W-1:0] exp_q[$];

  half_adder #(
    .WIDTH (W)
`ifdef HA_STATS_EN
    ,
    .CNT_W (TB_CNT)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .in_valid (in_valid),
    .sum      (sum),
    .carry    (carry),
    .sum_q    (sum_q),
    .carry_q  (carry_q),
    .valid_q  (valid_q)
`ifdef HA_STATS_EN
    ,
    .carry_cnt (carry_cnt)
`endif
  );

  // clock/reset block: clock held low first so the combinational-only phase sees no edges
  initial begin
    clk = 1'b0;
    #20;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: each bit position adds two one-bit numbers; low digit is sum, high digit carry.
  function automatic logic [2*W-1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] s;
    logic [W-1:0] c;
    for (int i = 0; i < W; i++) begin
      int t;
      t    = int'(x[i]) + int'(y[i]);
      s[i] = (t % 2) == 1;
      c[i] = (t / 2) == 1;
    end
    return {c, s};
  endfunction

  task automatic check_comb(input string tag);
    logic [2*W-1:0] r;
    r = ref_add(a, b);
    check_eq({tag, "_sum"}, 32'(sum), 32'(r[W-1:0]));
    check_eq({tag, "_carry"}, 32'(carry), 32'(r[2*W-1:W]));
    check_eq({tag, "_excl"}, 32'(sum & carry), 32'd0);
  endtask

  // driver: called at a falling edge; applies inputs, lets one rising edge pass, checks at next fall
  task automatic step(input logic r, input logic v, input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input string tag);
    logic [2*W-1:0] res;
    logic [SB_W-1:0] e;
    rst      = r;
    in_valid = v;
    a        = xa;
    b        = xb;
    #1;
    check_comb(tag);
    @(posedge clk);
    res = ref_add(xa, xb);
    if (r) begin
      m_sum = '0; m_carry = '0; m_valid = 1'b0; m_cnt = 0;
    end else if (v) begin
      m_sum   = res[W-1:0];
      m_carry = res[2*W-1:W];
      m_valid = 1'b1;
      if (res[2*W-1:W] != 0 && m_cnt < (2 ** TB_CNT) - 1) m_cnt++;
    end else begin
      m_valid = 1'b0;
    end
    exp_q.push_back({m_valid, m_carry, m_sum});
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq({tag, "_sum_q"}, 32'(sum_q), 32'(e[W-1:0]));
    check_eq({tag, "_carry_q"}, 32'(carry_q), 32'(e[2*W-1:W]));
    check_eq({tag, "_valid_q"}, 32'(valid_q), 32'(e[SB_W-1]));
    check_eq({tag, "_q_excl"}, 32'(sum_q & carry_q), 32'd0);
`ifdef HA_STATS_EN
    check_eq({tag, "_cnt"}, 32'(carry_cnt), 32'(m_cnt));
`endif
  endtask

  initial begin
    logic [W-1:0] ta;
    logic [W-1:0] tb;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    m_sum = '0; m_carry = '0; m_valid = 1'b0; m_cnt = 0;

    // combinational truth table, before any clock edge
    for (int i = 0; i < 4; i++) begin
      a = W'(i >> 1);
      b = W'(i & 1);
      #1;
      check_comb($sformatf("tt%0d", i));
      check_eq($sformatf("tt%0d_s_abs", i), 32'(sum[0]), 32'(i == 1 || i == 2));
      check_eq($sformatf("tt%0d_c_abs", i), 32'(carry[0]), 32'(i == 3));
      #1;
    end

    @(negedge clk);
    // reset dominates in_valid
    step(1'b1, 1'b1, 8'd1, 8'd1, "rst0");
    step(1'b1, 1'b1, 8'd1, 8'd1, "rst1");
    check_eq("rst_valid_abs", 32'(valid_q), 32'd0);
    // first valid after reset, then saturation run (five carry cycles total)
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'd1, 8'd1, $sformatf("sat%0d", i));
    check_eq("post_rst_carry_abs", 32'(carry_q), 32'd1);
`ifdef HA_STATS_EN
    check_eq("sat_abs", 32'(carry_cnt), 32'd3);
`endif
    step(1'b1, 1'b0, 8'd0, 8'd0, "sat_rst");

    // four-bit pattern, then hold
    step(1'b0, 1'b1, 8'h0C, 8'h0A, "w4");
    check_eq("w4_sum_abs", 32'(sum_q), 32'h06);
    check_eq("w4_carry_abs", 32'(carry_q), 32'h08);
    step(1'b0, 1'b0, 8'hFF, 8'h00, "w4_hold");
    check_eq("w4_hold_abs", 32'(sum_q), 32'h06);

    // reset mid-stream discards pending result
    step(1'b0, 1'b1, 8'hF0, 8'hFF, "mid_a");
    step(1'b1, 1'b1, 8'hAA, 8'h55, "mid_rst");
    step(1'b0, 1'b0, 8'h12, 8'h34, "mid_idle");
    step(1'b0, 1'b1, 8'h81, 8'h83, "mid_b");

    // random vectors
    for (int n = 0; n < 1000; n++) begin
      ta = W'($urandom);
      tb = W'($urandom);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, ta, tb, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
